// File: rtl/ppi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppi_pkg
// Description : Shared constants and types for the 8255-style PPI bus master:
//               register addresses, control-word field positions, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ppi_pkg;

  // PPI register select values driven on A[1:0]
  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  // Control-word fields: bit 7 selects mode-set (1) versus bit set/reset (0)
  localparam int CW_MODE_SET_BIT = 7;
  // Bit set/reset word: port C bit number in [3:1], set/clear value in bit 0
  localparam int CW_BSR_SEL_MSB  = 3;
  localparam int CW_BSR_SEL_LSB  = 1;
  localparam int CW_BSR_SET_BIT  = 0;
  // Mode-set word direction bits (1 = input)
  localparam int CW_DIR_PA_BIT   = 4;
  localparam int CW_DIR_PB_BIT   = 1;
  localparam int CW_DIR_PCL_BIT  = 0;
  localparam int CW_DIR_PCU_BIT  = 3;

  // Bus-cycle phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } ppi_state_e;

endpackage
`default_nettype wire

// File: rtl/ppi_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : ppi_phase_timer
// Description : Loadable down-counter timing each bus-cycle phase. The counter
//               stops at zero; expired is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] r_count;

  // Load on phase entry, otherwise count down and rest at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ppi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : ppi_bus_master
// Description : Turns one valid/ready request into a single PPI bus cycle
//               (CS, A, RD/WR strobe, D bus) with SETUP/STROBE/HOLD timing and
//               returns a one-cycle response, carrying read data for reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int CNT_W      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [1:0] A,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in
);

  // Every phase length must be at least one cycle and fit the counter
  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 ||
      SETUP_CYC > 2**CNT_W || STROBE_CYC > 2**CNT_W || HOLD_CYC > 2**CNT_W)
  begin : g_param_check
    $error("ppi_bus_master: *_CYC must lie in 1..2**CNT_W");
  end

  // Counter reload values: a phase of N cycles counts N-1 down to 0
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  ppi_state_e       r_state;
  logic             r_write;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_expired;

  ppi_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  // Reload the phase timer with the length of the phase being entered
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: begin
        w_load     = req_valid;
        w_load_val = SETUP_LD;
      end
      SETUP: begin
        w_load     = w_expired;
        w_load_val = STROBE_LD;
      end
      STROBE: begin
        w_load     = w_expired;
        w_load_val = HOLD_LD;
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  // Bus-cycle FSM; all pin and handshake outputs are registered here so they
  // change together on the phase boundary edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      CS        <= 1'b1;
      RD        <= 1'b1;
      WR        <= 1'b1;
      A         <= ADDR_PA;
      D_out     <= 8'h00;
      D_oe      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state   <= SETUP;
            r_write   <= req_write;
            CS        <= 1'b0;
            A         <= req_addr;
            D_out     <= req_wdata;
            D_oe      <= req_write;
            req_ready <= 1'b0;
          end
        end
        SETUP: begin
          if (w_expired) begin
            r_state <= STROBE;
            WR      <= ~r_write;
            RD      <= r_write;
          end
        end
        STROBE: begin
          if (w_expired) begin
            r_state <= HOLD;
            WR      <= 1'b1;
            RD      <= 1'b1;
            if (!r_write) begin
              rsp_rdata <= D_in;
            end
          end
        end
        HOLD: begin
          if (w_expired) begin
            r_state   <= IDLE;
            CS        <= 1'b1;
            D_oe      <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ppi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppi_bus_master
// Description : Self-checking bench for ppi_bus_master: vector table, corner
//               sequences, random traffic against a transaction-timeline model,
//               and a second instance with stretched phase timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppi_bus_master;

  localparam int S = 1, T = 2, H = 1, N = S + T + H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-timing instance
  logic       rst, req_valid, req_write, req_ready, rsp_valid;
  logic [1:0] req_addr, a;
  logic [7:0] req_wdata, d_in, rsp_rdata, d_out;
  logic       cs, rd, wr, d_oe;

  ppi_bus_master dut (
    .CLK (clk), .RST (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
    .CS (cs), .RD (rd), .WR (wr), .A (a),
    .D_out (d_out), .D_oe (d_oe), .D_in (d_in)
  );

  // Stretched-timing instance (2/3/2)
  logic       p_rst, p_req_valid, p_req_write, p_req_ready, p_rsp_valid;
  logic [1:0] p_req_addr, p_a;
  logic [7:0] p_req_wdata, p_d_in, p_rsp_rdata, p_d_out;
  logic       p_cs, p_rd, p_wr, p_d_oe;

  ppi_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .CNT_W(4)) dut_p (
    .CLK (clk), .RST (p_rst),
    .req_valid (p_req_valid), .req_ready (p_req_ready), .req_write (p_req_write),
    .req_addr (p_req_addr), .req_wdata (p_req_wdata),
    .rsp_valid (p_rsp_valid), .rsp_rdata (p_rsp_rdata),
    .CS (p_cs), .RD (p_rd), .WR (p_wr), .A (p_a),
    .D_out (p_d_out), .D_oe (p_d_oe), .D_in (p_d_in)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-timeline reference model ----------------
  // A transaction accepted at the end of cycle k occupies cycles k+1..k+N,
  // strobes during k+S+1..k+S+T, captures read data at the end of k+S+T and
  // responds in cycle k+N+1, when the master is idle again.
  int         cyc = 0;
  bit         m_has = 1'b0;
  int         m_k = 0;
  bit         m_w = 1'b0;
  logic [1:0] m_a = 2'b00;
  logic [7:0] m_d = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_has = 1'b0; m_a = 2'b00; m_d = 8'h00; m_rdata = 8'h00;
    end else begin
      if (m_has && !m_w && cyc == m_k + S + T) m_rdata = d_in;
      if ((!m_has || cyc > m_k + N) && req_valid) begin
        m_has = 1'b1; m_k = cyc; m_w = req_write; m_a = req_addr; m_d = req_wdata;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int          p;
    bit          busy, strb;
    logic [23:0] exp_v, act_v;
    if (chk_en) begin
      p     = m_has ? (cyc - m_k) : -1;
      busy  = m_has && p >= 1 && p <= N;
      strb  = m_has && p > S && p <= S + T;
      exp_v = {~busy, ~(strb && !m_w), ~(strb && m_w), m_a, m_d,
               busy && m_w, ~busy, m_has && (p == N + 1), m_rdata};
      act_v = {cs, rd, wr, a, d_out, d_oe, req_ready, rsp_valid, rsp_rdata};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle %0d pins: got %h expected %h", cyc, act_v, exp_v);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit         w;
    logic [1:0] ad;
    logic [7:0] wd;
    logic [7:0] din;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("vec_ready_wait", 32'(n < 50), 32'd1);
    req_valid = 1'b1; req_write = v.w; req_addr = v.ad; req_wdata = v.wd; d_in = v.din;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("vec_latency", 32'(n), 32'(N + 1));
    check("vec_rdata", 32'(rsp_rdata), 32'(v.exp_rd));
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 2'b11, 8'h80, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 2'b00, 8'h00, 8'h88, 8'h88};
    tbl[2] = '{1'b1, 2'b00, 8'h55, 8'h12, 8'h88};
    tbl[3] = '{1'b0, 2'b01, 8'h00, 8'h99, 8'h99};
    tbl[4] = '{1'b0, 2'b10, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{1'b0, 2'b11, 8'h00, 8'hFF, 8'hFF};
    tbl[6] = '{1'b1, 2'b10, 8'hAA, 8'h33, 8'hFF};
    tbl[7] = '{1'b0, 2'b01, 8'h00, 8'h5A, 8'h5A};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'b00;
    req_wdata = 8'h00; d_in = 8'h00;
    p_rst = 1'b1; p_req_valid = 1'b0; p_req_write = 1'b0; p_req_addr = 2'b00;
    p_req_wdata = 8'h00; p_d_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({cs, rd, wr, a, d_out, d_oe, req_ready, rsp_valid, rsp_rdata}),
          32'({1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}));
    rst = 1'b0; p_rst = 1'b0; chk_en = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-to-back with req_valid held high and inputs changing while busy
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b00; req_wdata = 8'h55; d_in = 8'h00;
    @(negedge clk);
    req_write = 1'b0; req_addr = 2'b01; req_wdata = 8'hC3; d_in = 8'h99;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("b2b_first_latency", 32'(n), 32'(N + 1));
    check("b2b_ready_in_rsp", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_accept", 32'({cs, a, d_oe}), 32'({1'b0, 2'b01, 1'b0}));
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("b2b_second_latency", 32'(n), 32'(N + 1));
    check("b2b_rdata", 32'(rsp_rdata), 32'h99);

    // Reset during the first strobe cycle of a write
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'b11; req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_strobe", 32'({cs, wr}), 32'({1'b0, 1'b0}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_pins", 32'({cs, wr, d_oe, req_ready}), 32'({1'b1, 1'b1, 1'b0, 1'b1}));
    n = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid === 1'b1) n++; end
    check("rst_no_rsp", 32'(n), 32'd0);

    // Random traffic, occasional resets, checked every cycle by the model
    repeat (600) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 2'($urandom_range(0, 3));
      req_wdata = 8'($urandom);
      d_in      = 8'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Stretched timing: read addr 10, D_in valid only in the last strobe cycle
    n = 0;
    while (p_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    p_req_valid = 1'b1; p_req_write = 1'b0; p_req_addr = 2'b10; p_d_in = 8'h11;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      p_req_valid = 1'b0;
      check($sformatf("p_pins_k+%0d", j), 32'({p_cs, p_rd, p_wr, p_d_oe, p_rsp_valid}),
            32'({!(j >= 1 && j <= 7), !(j >= 3 && j <= 5), 1'b1, 1'b0, (j == 8)}));
      if (j == 1) check("p_addr", 32'(p_a), 32'd2);
      if (j == 8) check("p_rdata", 32'(p_rsp_rdata), 32'hBD);
      p_d_in = (j == 5) ? 8'hBD : 8'(8'h40 + j);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
